// File: rtl/countdown_timer_arbiter_pkg.sv
// Shared types and defaults for the round-robin countdown timer arbiter.
// The state encoding is visible here so debug tooling and the parent agree on it.
package countdown_timer_arbiter_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int CW_DEFAULT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } timerState_e;

  // Index width for an n-entry one-hot; never below one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/countdown_timer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1, wrapping.
// The parent registers the result when it leaves IDLE.
module rr_arbiter
  import countdown_timer_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IW   = idxWidth(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0] hiMask;
  logic [NREQ-1:0] hiReq;
  logic            found;

  // Requests above the pointer win first; otherwise fall back to the lowest set request.
  always_comb begin
    hiMask = '0;
    for (int k = 0; k < NREQ; k++) begin
      hiMask[k] = (k > int'(ptr));
    end
    hiReq = req & hiMask;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && hiReq[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_arbiter.sv
// One shared CW-bit down-counter time-multiplexed among NREQ requesters.
// Every output is a register; the FSM owns grant, done, busy, count and the rr pointer.
module countdown_timer_arbiter
  import countdown_timer_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int CW   = CW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*CW-1:0] load_val,
  input  logic              tick,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [CW-1:0]     count
);

  localparam int IW = idxWidth(NREQ);

  timerState_e     state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic [CW-1:0]   count_q;

  logic [NREQ-1:0] arbGnt;
  logic [IW-1:0]   arbIdx_d;
  logic            ownerReq;
  logic [CW-1:0]   ownerLoad;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) uArb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arbGnt)
  );

  always_comb begin
    arbIdx_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arbGnt[k]) begin
        arbIdx_d = IW'(k);
      end
    end
    ownerReq  = req[owner_q];
    ownerLoad = load_val[owner_q*CW +: CW];
  end

  // Abort (owner drops req) is checked before the zero test so it never yields a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q <= ST_LOAD;
            grant_q <= arbGnt;
            owner_q <= arbIdx_d;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!ownerReq) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= owner_q;
          end else begin
            count_q <= ownerLoad;
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (!ownerReq) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= owner_q;
          end else if (count_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= grant_q;
          end else if (tick) begin
            count_q <= count_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= owner_q;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_countdown_timer_arbiter.sv
// Bench for countdown_timer_arbiter: directed scenarios with literal checkpoints,
// plus a transaction-level model compared against every output on each falling edge.
module tb_countdown_timer_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] load_val = '0;
  logic               tick = 1'b0;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [CW-1:0]      count;

  int checks = 0;
  int errors = 0;

  // Model: who owns the counter, which phase of its timeout it is in, and the count.
  int mOwner = -1;
  int mPhase = 0;
  int mCnt   = 0;
  int mPtr   = NREQ - 1;

  countdown_timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .load_val (load_val),
    .tick     (tick),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic t, input int cycles);
    req  = r;
    tick = t;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic setLoad(input int idx, input int v);
    load_val[idx*CW +: CW] = CW'(v);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  // Phases: 1 = value about to be loaded, 2 = counting, 3 = done being reported.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mOwner = -1;
      mPhase = 0;
      mCnt   = 0;
      mPtr   = NREQ - 1;
    end else if (mOwner < 0) begin
      if (req != '0) begin
        for (int off = 1; off <= NREQ; off++) begin
          int j;
          j = (mPtr + off) % NREQ;
          if (mOwner < 0 && req[j]) mOwner = j;
        end
        mPhase = 1;
      end
    end else if (mPhase == 3) begin
      mPtr   = mOwner;
      mOwner = -1;
    end else if (!req[mOwner]) begin
      mPtr   = mOwner;
      mOwner = -1;
    end else if (mPhase == 1) begin
      mCnt   = int'(load_val[mOwner*CW +: CW]);
      mPhase = 2;
    end else if (mCnt == 0) begin
      mPhase = 3;
    end else if (tick) begin
      mCnt = mCnt - 1;
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] ed;
    eg = (mOwner >= 0) ? NREQ'(1 << mOwner) : '0;
    ed = (mOwner >= 0 && mPhase == 3) ? eg : '0;
    checkOutput("model_grant", 32'(grant), 32'(eg));
    checkOutput("model_done",  32'(done),  32'(ed));
    checkOutput("model_busy",  {31'd0, busy}, {31'd0, (mOwner >= 0)});
    checkOutput("model_count", 32'(count), 32'(mCnt));
  end

  initial begin
    int n;
    int prevG;
    int nG;
    int gSeq[5];
    int doneCnt[NREQ];
    int decs;
    int dones;
    int wraps;
    int prevC;

    #1 rst = 1'b1;
    #22 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_busy",  {31'd0, busy}, 32'd0);
    checkOutput("reset_count", 32'(count), 32'd0);

    // Scenario 1: single requester, value 5, tick every other cycle.
    setLoad(0, 5);
    applyStimulus(4'b0001, 1'b0, 1);
    checkOutput("s1_grant", 32'(grant), 32'h1);
    applyStimulus(4'b0001, 1'b0, 1);
    checkOutput("s1_count_loaded", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, 1'b1, 1);
      applyStimulus(4'b0001, 1'b0, 1);
    end
    checkOutput("s1_done", 32'(done), 32'h1);
    checkOutput("s1_count_zero", 32'(count), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1);
    checkOutput("s1_busy_clear", {31'd0, busy}, 32'd0);
    checkOutput("s1_done_clear", 32'(done), 32'd0);

    // Scenario 2: all requesting from reset, every timeout 1, tick held high.
    rst = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      setLoad(i, 1);
      doneCnt[i] = 0;
    end
    req = 4'b1111;
    tick = 1'b1;
    prevG = 0;
    nG = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (grant != 0 && int'(grant) != prevG && nG < 5) begin
        gSeq[nG] = int'(grant);
        nG++;
      end
      prevG = int'(grant);
      for (int i = 0; i < NREQ; i++) if (done[i]) doneCnt[i]++;
    end
    checkOutput("s2_grants_seen", 32'(nG), 32'd5);
    checkOutput("s2_grant0", 32'(gSeq[0]), 32'h1);
    checkOutput("s2_grant1", 32'(gSeq[1]), 32'h2);
    checkOutput("s2_grant2", 32'(gSeq[2]), 32'h4);
    checkOutput("s2_grant3", 32'(gSeq[3]), 32'h8);
    checkOutput("s2_grant4", 32'(gSeq[4]), 32'h1);
    checkOutput("s2_done_r0", 32'(doneCnt[0]), 32'd2);
    checkOutput("s2_done_r1", 32'(doneCnt[1]), 32'd1);
    checkOutput("s2_done_r2", 32'(doneCnt[2]), 32'd1);
    checkOutput("s2_done_r3", 32'(doneCnt[3]), 32'd1);
    applyStimulus(4'b0000, 1'b0, 0);
    waitIdle();

    // Scenario 3: zero timeout completes with no tick.
    setLoad(2, 0);
    req = 4'b0100;
    tick = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 0 && n < 10);
    checkOutput("s3_done_latency", 32'(n), 32'd3);
    checkOutput("s3_done", 32'(done), 32'h4);
    checkOutput("s3_count", 32'(count), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1);

    // Scenario 4: owner 1 aborts at count 6, pending requester 2 follows.
    setLoad(1, 9);
    setLoad(2, 3);
    applyStimulus(4'b0110, 1'b0, 1);
    checkOutput("s4_grant1", 32'(grant), 32'h2);
    applyStimulus(4'b0110, 1'b0, 1);
    checkOutput("s4_count9", 32'(count), 32'd9);
    applyStimulus(4'b0110, 1'b1, 3);
    checkOutput("s4_count6", 32'(count), 32'd6);
    applyStimulus(4'b0100, 1'b0, 1);
    checkOutput("s4_abort_grant", 32'(grant), 32'd0);
    checkOutput("s4_abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("s4_abort_done", 32'(done), 32'd0);
    checkOutput("s4_abort_count", 32'(count), 32'd6);
    applyStimulus(4'b0100, 1'b0, 1);
    checkOutput("s4_grant2", 32'(grant), 32'h4);
    applyStimulus(4'b0000, 1'b0, 2);
    waitIdle();

    // Scenario 5: reset while counting; afterwards requester 0 beats requester 3.
    setLoad(3, 5);
    applyStimulus(4'b1000, 1'b0, 1);
    checkOutput("s5_grant3", 32'(grant), 32'h8);
    applyStimulus(4'b1000, 1'b0, 1);
    applyStimulus(4'b1000, 1'b1, 2);
    checkOutput("s5_count3", 32'(count), 32'd3);
    tick = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("s5_rst_grant", 32'(grant), 32'd0);
    checkOutput("s5_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("s5_rst_count", 32'(count), 32'd0);
    checkOutput("s5_rst_done", 32'(done), 32'd0);
    req = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1001, 1'b0, 1);
    checkOutput("s5_post_grant", 32'(grant), 32'h1);
    applyStimulus(4'b0000, 1'b0, 2);
    waitIdle();

    // Scenario 6: maximum timeout with tick held; exactly 15 decrements, no wrap.
    setLoad(0, 15);
    applyStimulus(4'b0001, 1'b0, 2);
    checkOutput("s6_count15", 32'(count), 32'd15);
    req = 4'b0001;
    tick = 1'b1;
    decs = 0;
    dones = 0;
    wraps = 0;
    for (int c = 0; c < 17; c++) begin
      prevC = int'(count);
      @(negedge clk);
      if (int'(count) < prevC) decs++;
      if (int'(count) > prevC) wraps++;
      if (done != 0) begin
        dones++;
        req = 4'b0000;
      end
    end
    checkOutput("s6_decrements", 32'(decs), 32'd15);
    checkOutput("s6_done_pulses", 32'(dones), 32'd1);
    checkOutput("s6_no_wrap", 32'(wraps), 32'd0);
    checkOutput("s6_final_count", 32'(count), 32'd0);
    applyStimulus(4'b0000, 1'b0, 1);
    waitIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
